ddr3_init_sequencer: RTL and testbench

DDR3_INIT_SEQUENCER -- requirements
Module: ddr3_init_sequencer

---
 rtl/ddr3_init_pkg.sv | 40 ++++
 rtl/ddr3_init_rom.sv | 94 +++++++++
 rtl/ddr3_init_sequencer.sv | 151 +++++++++++++++
 tb/tb_ddr3_init_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_init_pkg.sv
// Shared definitions for the DDR3 DFII init sequencer: register map, bit fields,
// FSM states and the step record used by the ROM.
package ddr3_init_pkg;

  localparam logic [7:0] OFS_CONTROL  = 8'h00;
  localparam logic [7:0] OFS_COMMAND  = 8'h04;
  localparam logic [7:0] OFS_ISSUE    = 8'h08;
  localparam logic [7:0] OFS_ADDRESS  = 8'h0C;
  localparam logic [7:0] OFS_BADDRESS = 8'h10;

  localparam logic [31:0] CTL_SEL     = 32'h1;
  localparam logic [31:0] CTL_CKE     = 32'h2;
  localparam logic [31:0] CTL_ODT     = 32'h4;
  localparam logic [31:0] CTL_RESET_N = 32'h8;

  localparam logic [31:0] CMD_CS  = 32'h1;
  localparam logic [31:0] CMD_WE  = 32'h2;
  localparam logic [31:0] CMD_CAS = 32'h4;
  localparam logic [31:0] CMD_RAS = 32'h8;

  localparam logic [4:0] LAST_STEP = 5'd23;

  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_DELAY, ST_DONE, ST_ERROR} state_e;

  typedef enum logic [4:0] {
    DS_CTL_RST, DS_CTL_UNRST, DS_CTL_CKE, DS_CTL_RUN,
    DS_MR0, DS_MR1, DS_MR2, DS_MR3,
    DS_BA0, DS_BA1, DS_BA2, DS_BA3,
    DS_CMD_MRS, DS_CMD_ZQCL, DS_ISSUE, DS_ZQ_ADDR
  } dsel_e;

  typedef enum logic [2:0] {TS_NONE, TS_RST, TS_CKE, TS_XPR, TS_MRD, TS_ZQ} tsel_e;

  typedef struct packed {
    logic [7:0] offset;
    dsel_e      dsel;
    tsel_e      tsel;
  } step_rec_t;

endpackage

// File: rtl/ddr3_init_rom.sv
// Combinational step table: maps a write index to its DFII offset, data word,
// post-write delay and a last-write flag.
module ddr3_init_rom
  import ddr3_init_pkg::*;
#(
  parameter int unsigned T_RST_CYC = 20000,
  parameter int unsigned T_CKE_CYC = 50000,
  parameter int unsigned T_XPR_CYC = 64,
  parameter int unsigned T_MRD_CYC = 4,
  parameter int unsigned T_ZQ_CYC  = 512,
  parameter logic [13:0] MR0 = 14'h0520,
  parameter logic [13:0] MR1 = 14'h0006,
  parameter logic [13:0] MR2 = 14'h0200,
  parameter logic [13:0] MR3 = 14'h0000
) (
  input  logic [4:0]  i_step,
  output logic [7:0]  o_offset,
  output logic [31:0] o_data,
  output logic [31:0] o_delay,
  output logic        o_last
);

  step_rec_t w_rec;

  always_comb begin
    w_rec = '{OFS_CONTROL, DS_CTL_RUN, TS_NONE};
    case (i_step)
      5'd0:  w_rec = '{OFS_CONTROL,  DS_CTL_RST,   TS_RST};
      5'd1:  w_rec = '{OFS_CONTROL,  DS_CTL_UNRST, TS_CKE};
      5'd2:  w_rec = '{OFS_CONTROL,  DS_CTL_CKE,   TS_XPR};
      5'd3:  w_rec = '{OFS_ADDRESS,  DS_MR2,       TS_NONE};
      5'd4:  w_rec = '{OFS_BADDRESS, DS_BA2,       TS_NONE};
      5'd5:  w_rec = '{OFS_COMMAND,  DS_CMD_MRS,   TS_NONE};
      5'd6:  w_rec = '{OFS_ISSUE,    DS_ISSUE,     TS_MRD};
      5'd7:  w_rec = '{OFS_ADDRESS,  DS_MR3,       TS_NONE};
      5'd8:  w_rec = '{OFS_BADDRESS, DS_BA3,       TS_NONE};
      5'd9:  w_rec = '{OFS_COMMAND,  DS_CMD_MRS,   TS_NONE};
      5'd10: w_rec = '{OFS_ISSUE,    DS_ISSUE,     TS_MRD};
      5'd11: w_rec = '{OFS_ADDRESS,  DS_MR1,       TS_NONE};
      5'd12: w_rec = '{OFS_BADDRESS, DS_BA1,       TS_NONE};
      5'd13: w_rec = '{OFS_COMMAND,  DS_CMD_MRS,   TS_NONE};
      5'd14: w_rec = '{OFS_ISSUE,    DS_ISSUE,     TS_MRD};
      5'd15: w_rec = '{OFS_ADDRESS,  DS_MR0,       TS_NONE};
      5'd16: w_rec = '{OFS_BADDRESS, DS_BA0,       TS_NONE};
      5'd17: w_rec = '{OFS_COMMAND,  DS_CMD_MRS,   TS_NONE};
      5'd18: w_rec = '{OFS_ISSUE,    DS_ISSUE,     TS_MRD};
      5'd19: w_rec = '{OFS_ADDRESS,  DS_ZQ_ADDR,   TS_NONE};
      5'd20: w_rec = '{OFS_BADDRESS, DS_BA0,       TS_NONE};
      5'd21: w_rec = '{OFS_COMMAND,  DS_CMD_ZQCL,  TS_NONE};
      5'd22: w_rec = '{OFS_ISSUE,    DS_ISSUE,     TS_ZQ};
      5'd23: w_rec = '{OFS_CONTROL,  DS_CTL_RUN,   TS_NONE};
      default: w_rec = '{OFS_CONTROL, DS_CTL_RUN, TS_NONE};
    endcase
  end

  always_comb begin
    o_data = 32'd0;
    case (w_rec.dsel)
      DS_CTL_RST:   o_data = CTL_ODT;
      DS_CTL_UNRST: o_data = CTL_ODT | CTL_RESET_N;
      DS_CTL_CKE:   o_data = CTL_ODT | CTL_RESET_N | CTL_CKE;
      DS_CTL_RUN:   o_data = CTL_SEL;
      DS_MR0:       o_data = {18'd0, MR0};
      DS_MR1:       o_data = {18'd0, MR1};
      DS_MR2:       o_data = {18'd0, MR2};
      DS_MR3:       o_data = {18'd0, MR3};
      DS_BA0:       o_data = 32'd0;
      DS_BA1:       o_data = 32'd1;
      DS_BA2:       o_data = 32'd2;
      DS_BA3:       o_data = 32'd3;
      DS_CMD_MRS:   o_data = CMD_CS | CMD_WE | CMD_CAS | CMD_RAS;
      DS_CMD_ZQCL:  o_data = CMD_CS | CMD_WE;
      DS_ISSUE:     o_data = 32'd1;
      DS_ZQ_ADDR:   o_data = 32'h0000_0400;
      default:      o_data = 32'd0;
    endcase
  end

  always_comb begin
    o_delay = 32'd0;
    case (w_rec.tsel)
      TS_RST:  o_delay = T_RST_CYC;
      TS_CKE:  o_delay = T_CKE_CYC;
      TS_XPR:  o_delay = T_XPR_CYC;
      TS_MRD:  o_delay = T_MRD_CYC;
      TS_ZQ:   o_delay = T_ZQ_CYC;
      default: o_delay = 32'd0;
    endcase
  end

  assign o_offset = w_rec.offset;
  assign o_last   = (i_step == LAST_STEP);

endmodule

// File: rtl/ddr3_init_sequencer.sv
// Wishbone master that walks the DDR3 init ROM, writing each step to the DFII
// block and holding the programmed delay after it.
module ddr3_init_sequencer
  import ddr3_init_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_9000,
  parameter int unsigned T_RST_CYC  = 20000,
  parameter int unsigned T_CKE_CYC  = 50000,
  parameter int unsigned T_XPR_CYC  = 64,
  parameter int unsigned T_MRD_CYC  = 4,
  parameter int unsigned T_ZQ_CYC   = 512,
  parameter logic [13:0] MR0        = 14'h0520,
  parameter logic [13:0] MR1        = 14'h0006,
  parameter logic [13:0] MR2        = 14'h0200,
  parameter logic [13:0] MR3        = 14'h0000,
  parameter int unsigned WB_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [4:0]  step,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_w,
  output logic [3:0]  wb_sel,
  input  logic        wb_ack,
  input  logic        wb_err
);

  state_e      r_state;
  logic [4:0]  r_step;
  logic        r_busy, r_done, r_error;
  logic        r_cyc, r_stb;
  logic [3:0]  r_sel;
  logic [31:0] r_adr, r_dat;
  logic [31:0] r_cnt, r_to;

  logic [7:0]  w_off;
  logic [31:0] w_data, w_delay, w_adr;
  logic        w_last;

  ddr3_init_rom #(
    .T_RST_CYC(T_RST_CYC), .T_CKE_CYC(T_CKE_CYC), .T_XPR_CYC(T_XPR_CYC),
    .T_MRD_CYC(T_MRD_CYC), .T_ZQ_CYC(T_ZQ_CYC),
    .MR0(MR0), .MR1(MR1), .MR2(MR2), .MR3(MR3)
  ) u_rom (
    .i_step  (r_step),
    .o_offset(w_off),
    .o_data  (w_data),
    .o_delay (w_delay),
    .o_last  (w_last)
  );

  assign w_adr = BASE_ADDR + {24'd0, w_off};

  // WRITE has a setup cycle with stb low so back-to-back writes always see a gap;
  // leaving DELAY launches the bus directly so a delay of N gives ack->stb = N+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_step  <= 5'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_sel   <= 4'h0;
      r_adr   <= 32'd0;
      r_dat   <= 32'd0;
      r_cnt   <= 32'd0;
      r_to    <= 32'd0;
    end else begin
      case (r_state)
        ST_WRITE: begin
          if (!r_stb) begin
            r_cyc <= 1'b1;
            r_stb <= 1'b1;
            r_sel <= 4'hF;
            r_adr <= w_adr;
            r_dat <= w_data;
            r_to  <= 32'd0;
          end else if (wb_err || (!wb_ack && r_to == WB_TIMEOUT - 1)) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_sel   <= 4'h0;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
            r_state <= ST_ERROR;
          end else if (wb_ack) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            r_sel <= 4'h0;
            if (w_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_step <= r_step + 5'd1;
              if (w_delay != 32'd0) begin
                r_cnt   <= w_delay;
                r_state <= ST_DELAY;
              end
            end
          end else begin
            r_to <= r_to + 32'd1;
          end
        end
        ST_DELAY: begin
          if (r_cnt == 32'd1) begin
            r_cnt   <= 32'd0;
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_sel   <= 4'hF;
            r_adr   <= w_adr;
            r_dat   <= w_data;
            r_to    <= 32'd0;
            r_state <= ST_WRITE;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        default: begin
          if (start) begin
            r_step  <= 5'd0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_state <= ST_WRITE;
          end
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign step     = r_step;
  assign wb_cyc   = r_cyc;
  assign wb_stb   = r_stb;
  assign wb_we    = r_cyc;
  assign wb_sel   = r_sel;
  assign wb_adr   = r_adr;
  assign wb_dat_w = r_dat;

endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// Bench for ddr3_init_sequencer: behavioural Wishbone slave with random latency
// and a write-list model of the init sequence checked every cycle.
module tb_ddr3_init_sequencer;

  localparam int T_RST = 4, T_CKE = 8, T_XPR = 2, T_MRD = 1, T_ZQ = 3, TMO = 20;
  localparam logic [31:0] BASE = 32'h0000_9000;

  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic busy, done, error, wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [4:0]  step;
  logic [31:0] wb_adr, wb_dat_w;
  logic [3:0]  wb_sel;

  int checks = 0, errors = 0;

  logic lat_rand = 1'b0, no_ack = 1'b0, err_mode = 1'b0;
  int wcnt = 0, lat = 0, s_idx = 0;

  typedef enum {M_IDLE, M_RUN, M_DONE, M_ERR} mph_e;
  mph_e m_ph = M_IDLE;
  int m_idx = 0, m_to = 0, m_ack_cyc = 0, m_gap = 0, t_stb = 0, cyc_n = 0;
  logic m_stb_prev = 1'b0;
  int gaps[24];
  logic [31:0] exp_adr[$], exp_dat[$], tr_adr[$], tr_dat[$];
  int exp_dly[$];
  logic [13:0] MRV[4] = '{14'h0520, 14'h0006, 14'h0200, 14'h0000};
  int mr_order[4] = '{2, 3, 1, 0};

  ddr3_init_sequencer #(
    .BASE_ADDR(BASE), .T_RST_CYC(T_RST), .T_CKE_CYC(T_CKE), .T_XPR_CYC(T_XPR),
    .T_MRD_CYC(T_MRD), .T_ZQ_CYC(T_ZQ), .WB_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .step(step), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // slave: answers after lat cycles of stb; err (with ack) on its 6th write in err_mode
  always @(posedge clk) begin
    if (!rst_n || !(wb_cyc && wb_stb)) begin
      wcnt <= 0;
    end else if (wb_ack || wb_err) begin
      wcnt <= 0;
      lat  <= lat_rand ? int'($urandom_range(0, 5)) : 0;
      if (!wb_err) s_idx <= s_idx + 1;
    end else begin
      wcnt <= wcnt + 1;
    end
    if (start && !busy) s_idx <= 0;
  end

  assign wb_ack = wb_cyc && wb_stb && (wcnt >= lat) && !no_ack;
  assign wb_err = wb_cyc && wb_stb && (wcnt >= lat) && err_mode && (s_idx == 5);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] off, input logic [31:0] d, input int dly);
    exp_adr.push_back(BASE + {24'd0, off});
    exp_dat.push_back(d);
    exp_dly.push_back(dly);
  endtask

  // per-cycle compare against the sequence model; model advances after the checks
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_ctl", {17'd0, busy, done, error, wb_cyc, wb_stb, wb_we, wb_sel, step}, 32'd0);
      chk("reset_bus", wb_adr | wb_dat_w, 32'd0);
      m_ph = M_IDLE;
      m_stb_prev = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(m_ph == M_RUN));
      chk("done", 32'(done), 32'(m_ph == M_DONE));
      chk("error", 32'(error), 32'(m_ph == M_ERR));
      if (m_ph != M_RUN) chk("bus_idle", 32'(wb_cyc | wb_stb), 32'd0);
      if (m_ph == M_ERR) chk("step_frozen", 32'(step), 32'(m_idx));
      if (m_ph == M_DONE) chk("step_done", 32'(step), 32'd23);
      if (m_ph == M_RUN && wb_stb) begin
        if (m_idx < 24) begin
          chk("wr_adr", wb_adr, exp_adr[m_idx]);
          chk("wr_dat", wb_dat_w, exp_dat[m_idx]);
          chk("wr_ctl", {25'd0, wb_cyc, wb_we, wb_sel, 1'b0}, {25'd0, 2'b11, 4'hF, 1'b0});
          chk("wr_step", 32'(step), 32'(m_idx));
        end else begin
          chk("extra_write", 32'd1, 32'd0);
        end
        if (!m_stb_prev) begin
          m_to = 0;
          if (m_idx == 0) begin
            t_stb = cyc_n;
          end else begin
            m_gap = cyc_n - m_ack_cyc;
            gaps[m_idx-1] = m_gap;
            if (exp_dly[m_idx-1] > 0) chk("delay_gap", 32'(m_gap), 32'(exp_dly[m_idx-1] + 1));
            else chk("min_gap", 32'(m_gap >= 2), 32'd1);
          end
        end
        m_to++;
      end else if (m_ph == M_RUN) begin
        chk("cyc_low", 32'(wb_cyc), 32'd0);
      end
      m_stb_prev = wb_stb;
      if (m_ph == M_RUN) begin
        if (wb_stb) begin
          if (wb_err) m_ph = M_ERR;
          else if (wb_ack) begin
            tr_adr.push_back(wb_adr);
            tr_dat.push_back(wb_dat_w);
            m_ack_cyc = cyc_n;
            m_idx++;
            if (m_idx == 24) m_ph = M_DONE;
          end else if (m_to == TMO) m_ph = M_ERR;
        end
      end else if (start) begin
        m_ph = M_RUN;
        m_idx = 0;
        m_stb_prev = 1'b0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic start_run();
    tr_adr.delete();
    tr_dat.delete();
    repeat ($urandom_range(1, 4)) @(posedge clk);
    pulse_start();
  endtask

  task automatic wait_end(input int budget);
    int k = 0;
    while (!(done || error) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      errors++;
      $display("FAIL wait_end timed out after %0d cycles", budget);
    end
  endtask

  task automatic wait_trace(input int n, input int budget);
    int k = 0;
    while (tr_adr.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      errors++;
      $display("FAIL wait_trace(%0d) timed out, got %0d writes", n, tr_adr.size());
    end
  endtask

  initial begin
    push(8'h00, 32'h04, T_RST);
    push(8'h00, 32'h0C, T_CKE);
    push(8'h00, 32'h0E, T_XPR);
    for (int g = 0; g < 4; g++) begin
      push(8'h0C, {18'd0, MRV[mr_order[g]]}, 0);
      push(8'h10, 32'(mr_order[g]), 0);
      push(8'h04, 32'h0F, 0);
      push(8'h08, 32'h01, T_MRD);
    end
    push(8'h0C, 32'h400, 0);
    push(8'h10, 32'h0, 0);
    push(8'h04, 32'h03, 0);
    push(8'h08, 32'h01, T_ZQ);
    push(8'h00, 32'h01, 0);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {27'd0, step}, 32'd0);

    // zero-wait slave: full sequence with literal pins on the write trace and delays
    start_run();
    wait_end(2000);
    chk("run1_done", 32'(done), 32'd1);
    chk("run1_writes", 32'(tr_adr.size()), 32'd24);
    if (tr_adr.size() == 24) begin
      chk("first_adr", tr_adr[0], 32'h9000);
      chk("first_dat", tr_dat[0], 32'h04);
      chk("mr2_a0", tr_adr[3], 32'h900C);  chk("mr2_d0", tr_dat[3], 32'h200);
      chk("mr2_a1", tr_adr[4], 32'h9010);  chk("mr2_d1", tr_dat[4], 32'h2);
      chk("mr2_a2", tr_adr[5], 32'h9004);  chk("mr2_d2", tr_dat[5], 32'h0F);
      chk("mr2_a3", tr_adr[6], 32'h9008);  chk("mr2_d3", tr_dat[6], 32'h1);
      chk("zq_adr", tr_dat[19], 32'h400);
      chk("last_adr", tr_adr[23], 32'h9000);
      chk("last_dat", tr_dat[23], 32'h01);
    end
    chk("gap_rst", 32'(gaps[0]), 32'd5);
    chk("gap_cke", 32'(gaps[1]), 32'd9);
    chk("gap_xpr", 32'(gaps[2]), 32'd3);
    chk("gap_mrd", 32'(gaps[6]), 32'd2);
    chk("gap_zq", 32'(gaps[22]), 32'd4);

    // error (with simultaneous ack) on write 5, then no further bus activity
    err_mode = 1'b1;
    start_run();
    wait_end(2000);
    chk("err_flag", 32'(error), 32'd1);
    chk("err_step", 32'(step), 32'd5);
    chk("err_busy_cyc", 32'(busy | wb_cyc), 32'd0);
    chk("err_writes", 32'(tr_adr.size()), 32'd5);
    repeat (20) @(negedge clk);
    chk("err_no_more", 32'(tr_adr.size()), 32'd5);
    err_mode = 1'b0;

    // restart from ERROR with random slave latency
    lat_rand = 1'b1;
    start_run();
    wait_end(4000);
    chk("rand_done", 32'(done), 32'd1);
    chk("rand_writes", 32'(tr_adr.size()), 32'd24);

    // never-acking slave
    no_ack = 1'b1;
    start_run();
    wait_end(500);
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_cycles", 32'(cyc_n - t_stb), 32'(TMO));
    chk("tmo_step", 32'(step), 32'd0);
    no_ack = 1'b0;

    // start while busy ignored, then async reset in the ZQ delay
    start_run();
    wait_trace(10, 2000);
    pulse_start();
    wait_trace(23, 2000);
    @(posedge clk);
    #1 chk("pre_reset_busy", 32'(busy), 32'd1);
    chk("pre_reset_writes", 32'(tr_adr.size()), 32'd23);
    rst_n = 1'b0;
    #1 chk("async_reset_ctl", {17'd0, busy, done, error, wb_cyc, wb_stb, wb_we, wb_sel, step}, 32'd0);
    chk("async_reset_bus", wb_adr | wb_dat_w, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", {26'd0, busy, wb_stb, step[3:0]}, 32'd0);

    start_run();
    wait_end(4000);
    chk("final_done", 32'(done), 32'd1);
    chk("final_writes", 32'(tr_adr.size()), 32'd24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
